// File: rtl/pid_ctrl_param_if.sv
// PID controller bus: run/line control, error samples in, wheel speeds and status out.
//   go, line_present, err_vld, error : driven by the error source (master)
//   lft_spd, right_spd, spd_vld, integ_sat : driven by the controller (slave)
interface pid_ctrl_param_if #(
    parameter int unsigned SPD_W = 12
);
    logic               go;
    logic               line_present;
    logic               err_vld;
    logic signed [15:0] error;
    logic [SPD_W-1:0]   lft_spd;
    logic [SPD_W-1:0]   right_spd;
    logic               spd_vld;
    logic               integ_sat;

    modport master (
        output go, line_present, err_vld, error,
        input  lft_spd, right_spd, spd_vld, integ_sat
    );

    modport slave (
        input  go, line_present, err_vld, error,
        output lft_spd, right_spd, spd_vld, integ_sat
    );
endinterface

// File: rtl/pid_ctrl_param.sv
// Parametrised PID steering controller: signed error samples in, left/right wheel speeds out.
// Two-stage pipeline: stage 1 registers P/D terms and updates the saturating integrator,
// stage 2 sums the terms and clamps the differential wheel speeds.
// Ports:
//   clk  : clock, all logic on posedge
//   rst  : synchronous active-high reset
//   bus  : pid_ctrl_param_if.slave (go, line_present, err_vld, error -> lft_spd, right_spd,
//          spd_vld, integ_sat)
// Build option: define PID_DTERM_EN to include the derivative history and d_term.
module pid_ctrl_param #(
    parameter int unsigned      ERR_W    = 10,
    parameter int unsigned      INT_W    = 16,
    parameter int unsigned      I_SHIFT  = 4,
    parameter int               P_COEF   = 3,
    parameter int               D_COEF   = 6,
    parameter int unsigned      D_DEPTH  = 2,
    parameter int unsigned      D_W      = 7,
    parameter int unsigned      SPD_W    = 12,
    parameter logic [SPD_W-1:0] BASE_SPD = 12'h400
) (
    input  logic             clk,
    input  logic             rst,
    pid_ctrl_param_if.slave  bus
);
    localparam int unsigned PT_W  = ERR_W + 5;
    localparam int unsigned DT_W  = D_W + 5;
    localparam int unsigned MX1   = (PT_W > INT_W) ? PT_W : INT_W;
    localparam int unsigned MX2   = (MX1 > DT_W) ? MX1 : DT_W;
    localparam int unsigned MX3   = (MX2 > SPD_W + 1) ? MX2 : SPD_W + 1;
    localparam int unsigned SUM_W = MX3 + 3;

    localparam logic signed [15:0]      ERR_MAX = 16'((2 ** (ERR_W - 1)) - 1);
    localparam logic signed [15:0]      ERR_MIN = 16'(-(2 ** (ERR_W - 1)));
    localparam logic signed [INT_W:0]   INT_MAX = (INT_W + 1)'((2 ** (INT_W - 1)) - 1);
    localparam logic signed [INT_W:0]   INT_MIN = (INT_W + 1)'(-(2 ** (INT_W - 1)));
    localparam logic signed [4:0]       P_C     = 5'(P_COEF);
    localparam logic signed [SUM_W-1:0] BASE_X  = SUM_W'(BASE_SPD);
    localparam logic signed [SUM_W-1:0] SPD_MAX = SUM_W'({SPD_W{1'b1}});

    // Elaboration-time parameter sanity checks.
    if (D_DEPTH < 1) begin : g_chk_depth
        $error("D_DEPTH must be at least 1");
    end
    if (P_COEF > 15 || P_COEF < -16 || D_COEF > 15 || D_COEF < -16) begin : g_chk_coef
        $error("P_COEF/D_COEF must fit a signed 5-bit gain");
    end

    logic                    smp;
    logic                    clr;
    logic                    lp_q;
    logic signed [15:0]      err_in;
    logic signed [ERR_W-1:0] err_sat;
    logic signed [PT_W-1:0]  p_prod;
    logic signed [INT_W:0]   isum;
    logic signed [INT_W-1:0] isat;
    logic                    iclamp;
    logic signed [DT_W-1:0]  d_calc;

    logic                    s1_vld;
    logic signed [PT_W-1:0]  p_term;
    logic signed [DT_W-1:0]  d_term;
    logic signed [INT_W-1:0] integ;
    logic                    integ_sat_q;

    logic signed [INT_W-1:0] i_term;
    logic signed [SUM_W-1:0] pid;
    logic [SPD_W-1:0]        lft_q;
    logic [SPD_W-1:0]        rgt_q;
    logic                    spd_vld_q;

    assign err_in = bus.error;
    assign smp    = bus.err_vld & bus.go;
    // Leaving run or re-acquiring the line restarts the integrator and history.
    assign clr    = ~bus.go | (bus.line_present & ~lp_q);

    // Input saturation, proportional product and integrator saturation.
    always_comb begin
        if (err_in > ERR_MAX) begin
            err_sat = ERR_MAX[ERR_W-1:0];
        end else if (err_in < ERR_MIN) begin
            err_sat = ERR_MIN[ERR_W-1:0];
        end else begin
            err_sat = err_in[ERR_W-1:0];
        end
        p_prod = PT_W'(err_sat) * PT_W'(P_C);
        isum   = (INT_W + 1)'(integ) + (INT_W + 1)'(err_sat);
        iclamp = 1'b1;
        if (isum > INT_MAX) begin
            isat = INT_MAX[INT_W-1:0];
        end else if (isum < INT_MIN) begin
            isat = INT_MIN[INT_W-1:0];
        end else begin
            isat   = isum[INT_W-1:0];
            iclamp = 1'b0;
        end
    end

`ifdef PID_DTERM_EN
    localparam int unsigned DF_W  = ERR_W + 1;
    localparam int unsigned CNT_W = $clog2(D_DEPTH + 1);
    localparam logic signed [DF_W-1:0] DIF_MAX = DF_W'((2 ** (D_W - 1)) - 1);
    localparam logic signed [DF_W-1:0] DIF_MIN = DF_W'(-(2 ** (D_W - 1)));
    localparam logic signed [4:0]      D_C     = 5'(D_COEF);

    logic signed [ERR_W-1:0] hist [D_DEPTH];
    logic [CNT_W-1:0]        hist_cnt;
    logic signed [DF_W-1:0]  diff;
    logic signed [D_W-1:0]   diff_sat;

    // Derivative against the sample D_DEPTH valid samples back, zero until history is full.
    always_comb begin
        diff = DF_W'(err_sat) - DF_W'(hist[D_DEPTH-1]);
        if (diff > DIF_MAX) begin
            diff_sat = DIF_MAX[D_W-1:0];
        end else if (diff < DIF_MIN) begin
            diff_sat = DIF_MIN[D_W-1:0];
        end else begin
            diff_sat = diff[D_W-1:0];
        end
        d_calc = (hist_cnt == CNT_W'(D_DEPTH)) ? DT_W'(diff_sat) * DT_W'(D_C) : '0;
    end

    // Sample history shift register and warm-up counter.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int i = 0; i < int'(D_DEPTH); i++) hist[i] <= '0;
            hist_cnt <= '0;
        end else if (smp) begin
            hist[0] <= err_sat;
            for (int i = 1; i < int'(D_DEPTH); i++) hist[i] <= hist[i-1];
            if (hist_cnt != CNT_W'(D_DEPTH)) hist_cnt <= hist_cnt + CNT_W'(1);
        end
    end
`else
    assign d_calc = '0;
`endif

    // Stage 1: P/D terms and integrator; a clearing sample still yields a P-only result.
    always_ff @(posedge clk) begin
        if (rst) begin
            lp_q        <= 1'b0;
            s1_vld      <= 1'b0;
            p_term      <= '0;
            d_term      <= '0;
            integ       <= '0;
            integ_sat_q <= 1'b0;
        end else begin
            lp_q   <= bus.line_present;
            s1_vld <= smp;
            if (smp) begin
                p_term <= p_prod;
                d_term <= clr ? '0 : d_calc;
            end
            if (clr) begin
                integ       <= '0;
                integ_sat_q <= 1'b0;
            end else if (smp) begin
                integ       <= isat;
                integ_sat_q <= iclamp;
            end
        end
    end

    // Stage 2 sum; integ here already includes the sample being completed.
    always_comb begin
        i_term = integ >>> I_SHIFT;
        pid    = SUM_W'(p_term) + SUM_W'(i_term) + SUM_W'(d_term);
    end

    function automatic logic [SPD_W-1:0] clamp_spd(input logic signed [SUM_W-1:0] v);
        if (v < 0) return '0;
        if (v > SPD_MAX) return '1;
        return v[SPD_W-1:0];
    endfunction

    // Stage 2: differential speeds; go low zeroes the wheels and drops the in-flight sample.
    always_ff @(posedge clk) begin
        if (rst || !bus.go) begin
            lft_q     <= '0;
            rgt_q     <= '0;
            spd_vld_q <= 1'b0;
        end else begin
            spd_vld_q <= s1_vld;
            if (s1_vld) begin
                lft_q <= clamp_spd(BASE_X + pid);
                rgt_q <= clamp_spd(BASE_X - pid);
            end
        end
    end

    assign bus.lft_spd   = lft_q;
    assign bus.right_spd = rgt_q;
    assign bus.spd_vld   = spd_vld_q;
    assign bus.integ_sat = integ_sat_q;
endmodule
